// File: rtl/vending_pkg.sv
// Shared definitions for the vending sequencer: state encoding (doubles as
// the display state_code) and the valid product-selection range.
package vending_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CREDIT   = 4'd1,
    ST_DISPENSE = 4'd2,
    ST_CHANGE   = 4'd3,
    ST_DONE     = 4'd4,
    ST_ERROR    = 4'd14
  } state_e;

  localparam logic [2:0] SEL_MIN = 3'd1;
  localparam logic [2:0] SEL_MAX = 3'd6;

  // True when the selection addresses a real product slot.
  function automatic logic sel_in_range(input logic [2:0] s);
    return (s >= SEL_MIN) && (s <= SEL_MAX);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Advance-button conditioner: 2-flop synchronizer, stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing
// samples, and a one-cycle pulse on each accepted 0->1 transition.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Stability tracking: count samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so bounces never accumulate.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/vending_sequencer.sv
// Vending controller: debounced advance, registered credit check and a
// timed IDLE/CREDIT/DISPENSE/CHANGE/DONE/ERROR sequence. All outputs are
// registered from next-state so they line up with state_code.
module vending_sequencer
  import vending_pkg::*;
#(
  parameter logic [3:0] PRICE           = 4'd3,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         DISPENSE_CYCLES = 8,
  parameter int         CHANGE_CYCLES   = 8,
  parameter int         ERROR_CYCLES    = 8,
  parameter int         TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] credit_in,
  input  logic       avance,
  input  logic [2:0] sel,
  output logic [3:0] state_code,
  output logic       credit_ok,
  output logic       dispense,
  output logic [2:0] product,
  output logic [3:0] change,
  output logic       busy,
  output logic       insufficient
);

  localparam int MAX_DC  = (DISPENSE_CYCLES > CHANGE_CYCLES) ? DISPENSE_CYCLES : CHANGE_CYCLES;
  localparam int MAX_ET  = (ERROR_CYCLES > TIMEOUT_CYCLES) ? ERROR_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_DC > MAX_ET) ? MAX_DC : MAX_ET;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // The timer counts N-1 down to 0, so a state lasts exactly N cycles and
  // the largest count fits in clog2(N) bits.
  localparam logic [TW-1:0] TIMEOUT_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] DISPENSE_LOAD = TW'(DISPENSE_CYCLES - 1);
  localparam logic [TW-1:0] CHANGE_LOAD   = TW'(CHANGE_CYCLES - 1);
  localparam logic [TW-1:0] ERROR_LOAD    = TW'(ERROR_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cred_q, cred_d;
  logic [2:0]    sel_lat_q, sel_lat_d;
  logic          credit_ok_q;
  logic          dispense_q, dispense_d;
  logic [2:0]    product_q, product_d;
  logic [3:0]    change_q, change_d;
  logic          busy_q, busy_d;
  logic          insuff_q, insuff_d;
  logic          adv_pulse;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (avance),
    .pulse_o(adv_pulse)
  );

  // Next-state, timer, latches and next-output decode.
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q != '0) ? timer_q - TW'(1) : '0;
    cred_d    = cred_q;
    sel_lat_d = sel_lat_q;
    insuff_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (credit_in != 4'd0) begin
          state_d = ST_CREDIT;
          timer_d = TIMEOUT_LOAD;
        end
      end
      ST_CREDIT: begin
        if (credit_in == 4'd0) begin
          state_d = ST_IDLE;
        end else if (adv_pulse) begin
          if (credit_in >= PRICE) begin
            if (sel_in_range(sel)) begin
              state_d   = ST_DISPENSE;
              timer_d   = DISPENSE_LOAD;
              cred_d    = credit_in;
              sel_lat_d = sel;
            end else begin
              state_d = ST_ERROR;
              timer_d = ERROR_LOAD;
            end
          end else begin
            insuff_d = 1'b1;
            timer_d  = TIMEOUT_LOAD;
          end
        end else if (timer_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        if (timer_q == '0) begin
          if (cred_q > PRICE) begin
            state_d = ST_CHANGE;
            timer_d = CHANGE_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CHANGE: begin
        if (timer_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (credit_in == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (timer_q == '0) begin
          if (credit_in == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CREDIT;
            timer_d = TIMEOUT_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    dispense_d = (state_d == ST_DISPENSE);
    product_d  = dispense_d ? sel_lat_d : 3'd0;
    // CHANGE is only entered with latched credit above PRICE, so no underflow.
    change_d   = (state_d == ST_CHANGE) ? (cred_d - PRICE) : 4'd0;
    busy_d     = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE) || (state_d == ST_ERROR);
  end

  // State, timer, latched selection and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cred_q      <= 4'd0;
      sel_lat_q   <= 3'd0;
      credit_ok_q <= 1'b0;
      dispense_q  <= 1'b0;
      product_q   <= 3'd0;
      change_q    <= 4'd0;
      busy_q      <= 1'b0;
      insuff_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cred_q      <= cred_d;
      sel_lat_q   <= sel_lat_d;
      credit_ok_q <= (credit_in >= PRICE);
      dispense_q  <= dispense_d;
      product_q   <= product_d;
      change_q    <= change_d;
      busy_q      <= busy_d;
      insuff_q    <= insuff_d;
    end
  end

  assign state_code   = state_q;
  assign credit_ok    = credit_ok_q;
  assign dispense     = dispense_q;
  assign product      = product_q;
  assign change       = change_q;
  assign busy         = busy_q;
  assign insufficient = insuff_q;

endmodule

// File: doc/vending_sequencer.md
Name: vending_sequencer

Overview:
Clocked controller that sequences the vending datapath: it debounces the advance button, checks switch credit against a price, and walks through selection, dispense, change and completion. Its state_code output drives the existing 7-segment decoder and its credit_ok output replaces the combinational credit flag at the top level. It sits between the ui_in pins and the display path.

Parameters:
PRICE, 4'd3, product price in credit units; valid 1..15
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a new button level; >=1
DISPENSE_CYCLES, 8, cycles the dispense output is held high; >=1
CHANGE_CYCLES, 8, cycles the change output is presented; >=1
ERROR_CYCLES, 8, cycles spent in ERROR; >=1
TIMEOUT_CYCLES, 64, cycles without an advance pulse in CREDIT before returning to IDLE; >=1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
credit_in  input  4  credit switch value, 0 = no credit
avance  input  1  raw advance button, asynchronous and bouncy
sel  input  3  product select; valid values are 1..6
state_code  output  4  current state number for the display decoder
credit_ok  output  1  registered flag: credit_in >= PRICE
dispense  output  1  high while a product is being dispensed
product  output  3  latched selection; 0 when not in DISPENSE
change  output  4  latched change value (credit - PRICE) during CHANGE, else 0
busy  output  1  high in DISPENSE, CHANGE and ERROR
insufficient  output  1  one-cycle pulse on an advance with credit below PRICE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. While rst is high at a clock edge, every register clears on that edge.
- Reset values: state IDLE, state_code 0, every output 0, timer 0, debounce level 0, latched credit and sel 0.
- Reset asserted mid-operation aborts the operation immediately. dispense and change drop on the same edge.
- Advance path:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level takes the synchronized value after DEBOUNCE_CYCLES consecutive equal samples that differ from the current level.
  - adv_pulse is high for one cycle on a 0->1 change of the debounced level.
  - The FSM reacts on the edge after adv_pulse.
- credit_ok is registered and has 1-cycle latency from credit_in.
- A single down-counter timer is shared by all timed states. Width is clog2 of the largest *_CYCLES parameter. It is loaded on state entry and does not wrap: it holds at 0.
- State machine (state_code in brackets):
  - IDLE [0]: when credit_in != 0, go to CREDIT and load TIMEOUT_CYCLES.
  - CREDIT [1]:
    - credit_in == 0: go to IDLE. This has priority over everything else.
    - adv_pulse with credit_in >= PRICE and sel in 1..6: latch credit_in and sel, go to DISPENSE, load DISPENSE_CYCLES.
    - adv_pulse with credit_in >= PRICE and sel 0 or 7: go to ERROR, load ERROR_CYCLES.
    - adv_pulse with credit_in < PRICE: pulse insufficient for 1 cycle, stay, reload the timeout.
    - Timer reaches 0 with no adv_pulse: go to IDLE.
  - DISPENSE [2]:
    - dispense = 1 and product = latched sel for exactly DISPENSE_CYCLES cycles.
    - Then go to CHANGE with CHANGE_CYCLES loaded if latched credit > PRICE, otherwise go to DONE.
    - Changes on credit_in, sel and adv_pulse are ignored.
  - CHANGE [3]: change = latched credit - PRICE (4-bit, never negative) for CHANGE_CYCLES cycles, then go to DONE.
  - DONE [4]: wait for credit_in == 0, then go to IDLE. adv_pulse is ignored.
  - ERROR [14]: held for ERROR_CYCLES cycles, then go to CREDIT and reload the timeout. If credit_in == 0 at that point, go to IDLE instead.
- Outputs are registered and aligned with state: dispense rises on the first DISPENSE cycle and falls on the cycle the state leaves DISPENSE.
- Unreachable state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package vending_pkg holds:
  - the state enum and its state_code values (IDLE=0, CREDIT=1, DISPENSE=2, CHANGE=3, DONE=4, ERROR=14);
  - the valid-selection range constants (SEL_MIN=1, SEL_MAX=6).
- One sub-module, button_debounce: synchronizer, stability counter and rising-edge pulse. Parameter: DEBOUNCE_CYCLES.

Test Plan:
- Reset, then credit_in=0 and avance bouncing for 3 cycles -> state_code stays 0, all outputs 0, no adv_pulse.
- credit_in=2, sel=3, clean avance press -> insufficient pulses once, state_code stays 1, dispense never rises.
- credit_in=5, sel=2, press -> state_code 2 with dispense=1 and product=2 for exactly 8 cycles, then state_code 3 with change=2 for 8 cycles, then 4. Setting credit_in=0 -> state_code 0.
- credit_in=3, sel=6, press -> DISPENSE for 8 cycles, then directly DONE (change stays 0).
- credit_in=4, sel=0, press -> state_code 14 for 8 cycles, then 1. With credit_in cleared during ERROR -> 0.
- credit_in=4, no press for 64 cycles -> returns to 0. Separately, rst asserted mid-DISPENSE -> dispense=0 and state_code=0 on the next edge.
